// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the wait-state data memory responder.
// State encodings are fixed so checkers can compare against them directly.
package data_mem_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_ram.sv
// Single-port synchronous word array: registered read, read-first on a write edge.
// Kept standalone so a technology macro can replace it.
module data_mem_ram #(
    parameter int XLEN       = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic                  write_en,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       rdata
);

    logic [XLEN-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[index] <= wdata;
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Wait-state data memory responder: accepts one request, waits WAIT_STATES
// cycles, accesses the word array and acknowledges with a one-cycle ready.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic            clock_in,
    input  logic            reset_in,
    input  logic            data_mem_valid_in,
    input  logic            data_mem_write_in,
    input  logic [XLEN-1:0] data_mem_addr_in,
    input  logic [XLEN-1:0] data_mem_wdata_in,
    output logic [XLEN-1:0] data_mem_rdata_out,
    output logic            data_mem_ready_out
);

    // Handshake: a request is accepted on the rising edge where valid is high
    // and the FSM is IDLE; its fields are latched then and inputs are ignored
    // until IDLE again. ready is a one-cycle pulse and rdata is valid with it.

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      count, count_nxt;
    logic                  latch_en;
    logic                  access;
    logic                  req_write;
    logic [DEPTH_LOG2-1:0] req_index;
    logic [XLEN-1:0]       req_wdata;
    logic [XLEN-1:0]       rdata_hold;
    logic [XLEN-1:0]       ram_rdata;
    logic                  acc_write;
    logic [DEPTH_LOG2-1:0] acc_index;
    logic [XLEN-1:0]       acc_wdata;
    logic                  ram_we;
    logic                  read_ack;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{data_mem_addr_in[XLEN-1:DEPTH_LOG2+2], data_mem_addr_in[1:0]};

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        latch_en  = 1'b0;
        access    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (data_mem_valid_in) begin
                    latch_en  = 1'b1;
                    count_nxt = WAIT_LOAD;
                    if (WAIT_STATES == 0) begin
                        access    = 1'b1;
                        state_nxt = ST_ACK;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                count_nxt = count - 1'b1;
                if (count <= CNT_W'(1)) begin
                    access    = 1'b1;
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Zero-wait accesses happen on the accepting edge, before the latches hold the request.
    assign acc_write = (state == ST_IDLE) ? data_mem_write_in : req_write;
    assign acc_index = (state == ST_IDLE) ? data_mem_addr_in[DEPTH_LOG2+1:2] : req_index;
    assign acc_wdata = (state == ST_IDLE) ? data_mem_wdata_in : req_wdata;
    assign ram_we    = access & acc_write & ~reset_in;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state      <= ST_IDLE;
            count      <= '0;
            req_write  <= 1'b0;
            req_index  <= '0;
            req_wdata  <= '0;
            rdata_hold <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (latch_en) begin
                req_write <= data_mem_write_in;
                req_index <= data_mem_addr_in[DEPTH_LOG2+1:2];
                req_wdata <= data_mem_wdata_in;
            end
            if (read_ack) begin
                rdata_hold <= ram_rdata;
            end
        end
    end

    data_mem_ram #(
        .XLEN       (XLEN),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clock    (clock_in),
        .write_en (ram_we),
        .index    (acc_index),
        .wdata    (acc_wdata),
        .rdata    (ram_rdata)
    );

    // Fresh array data is shown during a read ACK; otherwise the last read value is held.
    assign read_ack           = (state == ST_ACK) && !req_write;
    assign data_mem_rdata_out = read_ack ? ram_rdata : rdata_hold;
    assign data_mem_ready_out = (state == ST_ACK);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a WAIT_STATES=2 instance for directed and random
// transactions, and a WAIT_STATES=0 instance fed with valid held high.
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0, write = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        valid0 = 1'b0, write0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [31:0] rdata0;
    logic        ready0;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem  [0:1023];
    bit          written    [0:1023];
    logic [31:0] model_rdata = '0;
    logic [31:0] model_mem0 [0:1023];
    logic [31:0] model_rdata0 = '0;
    logic [31:0] exp_q [$];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    data_mem_ctrl #(.XLEN(32), .DEPTH_LOG2(10), .WAIT_STATES(WS)) u_dut (
        .clock_in           (clk),
        .reset_in           (rst),
        .data_mem_valid_in  (valid),
        .data_mem_write_in  (write),
        .data_mem_addr_in   (addr),
        .data_mem_wdata_in  (wdata),
        .data_mem_rdata_out (rdata),
        .data_mem_ready_out (ready)
    );

    data_mem_ctrl #(.XLEN(32), .DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut0 (
        .clock_in           (clk),
        .reset_in           (rst),
        .data_mem_valid_in  (valid0),
        .data_mem_write_in  (write0),
        .data_mem_addr_in   (addr0),
        .data_mem_wdata_in  (wdata0),
        .data_mem_rdata_out (rdata0),
        .data_mem_ready_out (ready0)
    );

    // Word index from the aliasing rule: byte address modulo 4*1024, divided by 4.
    function automatic int widx(input logic [31:0] a);
        return int'((a % 32'd4096) / 32'd4);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_mid_cycle();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_state", 32'(u_dut.state), 32'(ST_IDLE));
        model_rdata  = '0;
        model_rdata0 = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction on the WS=2 instance; inputs are scrambled right after acceptance.
    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] sa, input logic [31:0] sd);
        int   edges;
        logic [31:0] exp_rd;
        @(negedge clk);
        valid = 1'b1; write = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        edges = 1;
        if (w) begin
            model_mem[widx(a)] = d;
            written[widx(a)]   = 1'b1;
        end else begin
            model_rdata = model_mem[widx(a)];
        end
        exp_q.push_back(model_rdata);
        write = ~w; addr = sa; wdata = sd;
        while (ready !== 1'b1 && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            valid = 1'b0;
        end
        check("latency", 32'(edges), 32'(WS + 1));
        check("ready_hi", 32'(ready), 32'd1);
        exp_rd = exp_q.pop_front();
        check("ack_rdata", rdata, exp_rd);
        valid = 1'b0;
        @(posedge clk);
        #1;
        check("ready_pulse", 32'(ready), 32'd0);
        check("rdata_hold", rdata, model_rdata);
    endtask

    initial begin : main
        bit          any_ready;
        logic [31:0] a, d, exp_rd;
        bit          w;
        int          k, j;

        for (int i = 0; i < 1024; i++) written[i] = 1'b0;

        // reset asserted asynchronously mid-cycle
        reset_mid_cycle();

        // write then read, with address/data changes during WAIT ignored
        txn(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0, 32'h0);
        txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0020, 32'h1234_5678);
        txn(1'b0, 32'h0000_0010, 32'h0, 32'h0000_0020, 32'h0);
        txn(1'b0, 32'h0000_0020, 32'h0, 32'h0000_0010, 32'h0);

        // aliasing and ignored low address bits
        txn(1'b1, 32'h0000_1013, 32'hA5A5_A5A5, 32'h0, 32'h0);
        txn(1'b0, 32'h0000_0010, 32'h0, 32'h0, 32'h0);

        // reset during WAIT of a write drops the write and never acks it
        txn(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 32'h0);
        @(negedge clk);
        valid = 1'b1; write = 1'b1; addr = 32'h0000_0040; wdata = 32'h1111_1111;
        @(posedge clk);
        #1;
        valid = 1'b0;
        check("abort_wait_ready", 32'(ready), 32'd0);
        #3 rst = 1'b1;
        #1;
        check("abort_rst_ready", 32'(ready), 32'd0);
        check("abort_rst_rdata", rdata, 32'd0);
        check("abort_rst_state", 32'(u_dut.state), 32'(ST_IDLE));
        model_rdata  = '0;
        model_rdata0 = '0;
        @(negedge clk);
        rst = 1'b0;
        any_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) any_ready = 1'b1;
        end
        check("abort_no_ready", 32'(any_ready), 32'd0);
        txn(1'b0, 32'h0000_0040, 32'h0, 32'h0, 32'h0);

        // randomized traffic over a small aliased word set
        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(0, 15);
            a = ($urandom & 32'hFFFF_F000) | 32'(((k + 64) << 2)) | 32'($urandom_range(0, 3));
            w = written[widx(a)] ? 1'($urandom_range(0, 1)) : 1'b1;
            d = $urandom;
            txn(w, a, d, $urandom, $urandom);
        end

        // zero wait states with valid held high: accepts on every other edge
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            valid0 = 1'b1;
            if (i % 2 == 0) begin
                j = i / 2;
                if (j < 8) begin
                    w = 1'b1;
                    k = j;
                end else begin
                    w = 1'($urandom_range(0, 1));
                    k = $urandom_range(0, 7);
                end
                a = ($urandom & 32'hFFFF_F000) | 32'(k << 2) | 32'($urandom_range(0, 3));
                d = $urandom;
                if (w) model_mem0[widx(a)] = d;
                else   model_rdata0 = model_mem0[widx(a)];
                exp_q.push_back(model_rdata0);
            end else begin
                w = 1'($urandom_range(0, 1));
                a = $urandom;
                d = $urandom;
            end
            write0 = w; addr0 = a; wdata0 = d;
            @(posedge clk);
            #1;
            if (i % 2 == 0) begin
                check("zws_ready_hi", 32'(ready0), 32'd1);
                exp_rd = exp_q.pop_front();
                check("zws_rdata", rdata0, exp_rd);
            end else begin
                check("zws_ready_lo", 32'(ready0), 32'd0);
                check("zws_rdata_hold", rdata0, model_rdata0);
            end
        end
        valid0 = 1'b0;

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
